// File: rtl/drum_step_sequencer.sv
// Purpose: drum pattern store (STEPS x TRACKS) with edit toggling, tempo playback and raw pad pass-through.
// Latency: trig/step/step_tick are registered (1 clock after the deciding edge); pattern_col is a combinational read.
// Backpressure: none; strobes and triggers are single-cycle pulses that consumers must accept when issued.
module drum_step_sequencer #(
    parameter int TRACKS = 4,
    parameter int STEPS  = 8,
    parameter int SW     = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode_i,
    input  logic [TRACKS-1:0] pad_i,
    input  logic [SW-1:0]     sel_step_i,
    input  logic              clear_i,
    input  logic [15:0]       period_i,
    output logic [TRACKS-1:0] trig_o,
    output logic [SW-1:0]     step_o,
    output logic              step_tick_o,
    output logic [TRACKS-1:0] pattern_col_o
);

    typedef enum logic [1:0] {
        S_EDIT = 2'd0,
        S_PLAY = 2'd1,
        S_RAW  = 2'd2
    } state_t;

    typedef logic [STEPS-1:0][TRACKS-1:0] pattern_t;

    state_t            state_q, state_d;
    pattern_t          pattern_q, pattern_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [SW-1:0]     step_q, step_d;
    logic [TRACKS-1:0] trig_q, trig_d;
    logic              tick_q, tick_d;

    // Next state and outputs: mode picks the state every edge; playback reads the pre-edge pattern.
    always_comb begin
        state_d   = S_EDIT;
        pattern_d = pattern_q;
        cnt_d     = '0;
        step_d    = '0;
        trig_d    = '0;
        tick_d    = 1'b0;

        case (mode_i)
            2'd1:    state_d = S_PLAY;
            2'd2:    state_d = S_RAW;
            default: state_d = S_EDIT;
        endcase

        case (state_d)
            S_PLAY: begin
                if (state_q != S_PLAY) begin
                    // Entry: issue step 0 immediately.
                    trig_d = pattern_q[0];
                    tick_d = 1'b1;
                end else if (cnt_q >= period_i) begin
                    // >= so a lowered period advances at once instead of wrapping the counter.
                    step_d = step_q + SW'(1);
                    trig_d = pattern_q[step_d];
                    tick_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 16'd1;
                    step_d = step_q;
                end
            end
            S_RAW: begin
                trig_d = pad_i;
            end
            default: begin
                pattern_d[sel_step_i] = pattern_q[sel_step_i] ^ pad_i;
            end
        endcase

        // Clear wins over a same-cycle toggle.
        if (clear_i) begin
            pattern_d = '0;
        end
    end

    // State, pattern and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_EDIT;
            pattern_q <= '0;
            cnt_q     <= '0;
            step_q    <= '0;
            trig_q    <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            trig_q    <= trig_d;
            tick_q    <= tick_d;
        end
    end

    assign trig_o        = trig_q;
    assign step_o        = step_q;
    assign step_tick_o   = tick_q;
    assign pattern_col_o = pattern_q[sel_step_i];

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Bench for drum_step_sequencer: directed stimulus, timestamp-based playback model, per-cycle compare.
module tb_drum_step_sequencer;

    localparam int TRACKS = 4;
    localparam int STEPS  = 8;
    localparam int SW     = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [TRACKS-1:0] pad = '0;
    logic [SW-1:0]     sel_step = '0;
    logic              clear = 1'b0;
    logic [15:0]       period = 16'd0;
    logic [TRACKS-1:0] trig;
    logic [SW-1:0]     step;
    logic              step_tick;
    logic [TRACKS-1:0] pattern_col;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    drum_step_sequencer #(.TRACKS(TRACKS), .STEPS(STEPS), .SW(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_i       (mode),
        .pad_i        (pad),
        .sel_step_i   (sel_step),
        .clear_i      (clear),
        .period_i     (period),
        .trig_o       (trig),
        .step_o       (step),
        .step_tick_o  (step_tick),
        .pattern_col_o(pattern_col)
    );

    // Model: pattern as an array, playback as "time since last issued step exceeds period".
    logic [TRACKS-1:0] m_pat [STEPS];
    logic [TRACKS-1:0] m_trig;
    int                m_step;
    logic              m_tick;
    bit                m_playing;
    longint            cyc;
    longint            last_issue;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) m_pat[i] = '0;
            m_trig = '0; m_step = 0; m_tick = 1'b0; m_playing = 1'b0;
            cyc = 0; last_issue = 0;
        end else begin
            cyc = cyc + 1;
            if (mode == 2'd1) begin
                if (!m_playing) begin
                    m_playing = 1'b1; m_step = 0; m_trig = m_pat[0];
                    m_tick = 1'b1; last_issue = cyc;
                end else if ((cyc - last_issue) > longint'(period)) begin
                    m_step = (m_step + 1) % STEPS; m_trig = m_pat[m_step];
                    m_tick = 1'b1; last_issue = cyc;
                end else begin
                    m_trig = '0; m_tick = 1'b0;
                end
            end else begin
                m_playing = 1'b0; m_step = 0; m_tick = 1'b0;
                m_trig = (mode == 2'd2) ? pad : '0;
            end
            if (clear) begin
                for (int i = 0; i < STEPS; i++) m_pat[i] = '0;
            end else if (mode == 2'd0 || mode == 2'd3) begin
                m_pat[sel_step] = m_pat[sel_step] ^ pad;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; compare all outputs against the model at the falling edge.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (rst_n) begin
                cmp("model_trig", 32'(trig), 32'(m_trig));
                cmp("model_step", 32'(step), 32'(m_step));
                cmp("model_tick", 32'(step_tick), 32'(m_tick));
                cmp("model_col", 32'(pattern_col), 32'(m_pat[sel_step]));
            end
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk); @(negedge clk);
        cmp("rst_trig", 32'(trig), 32'h0);
        cmp("rst_step", 32'(step), 32'h0);
        cmp("rst_tick", 32'(step_tick), 32'h0);
        cmp("rst_col", 32'(pattern_col), 32'h0);
        rst_n = 1'b1;

        // EDIT toggle twice
        sel_step = 3'd2; pad = 4'b0101; run(1);
        cmp("edit_set", 32'(pattern_col), 32'h5);
        pad = 4'b0000; run(1);
        pad = 4'b0101; run(1);
        cmp("edit_untoggle", 32'(pattern_col), 32'h0);

        // Program step0=0001, step1=0010, then PLAY with period 3
        sel_step = 3'd0; pad = 4'b0001; run(1);
        sel_step = 3'd1; pad = 4'b0010; run(1);
        pad = 4'b0000; period = 16'd3; mode = 2'd1; run(1);
        cmp("play_entry_trig", 32'(trig), 32'h1);
        cmp("play_entry_step", 32'(step), 32'h0);
        cmp("play_entry_tick", 32'(step_tick), 32'h1);
        run(3);
        cmp("play_gap_tick", 32'(step_tick), 32'h0);
        run(1);
        cmp("play_step1_trig", 32'(trig), 32'h2);
        cmp("play_step1_step", 32'(step), 32'h1);
        run(28);
        cmp("play_wrap_step", 32'(step), 32'h0);
        cmp("play_wrap_trig", 32'(trig), 32'h1);
        cmp("play_wrap_tick", 32'(step_tick), 32'h1);

        // period 0: one step per clock
        period = 16'd0; run(10);
        cmp("p0_step", 32'(step), 32'h2);
        cmp("p0_tick", 32'(step_tick), 32'h1);

        // RAW pass-through
        mode = 2'd2; run(1);
        pad = 4'b1000; run(1);
        cmp("raw_trig", 32'(trig), 32'h8);
        cmp("raw_step", 32'(step), 32'h0);
        pad = 4'b0000; run(1);
        cmp("raw_trig_off", 32'(trig), 32'h0);
        sel_step = 3'd0; #1;
        cmp("raw_pat_kept", 32'(pattern_col), 32'h1);

        // Clear beats a same-cycle toggle in EDIT
        mode = 2'd0; clear = 1'b1; pad = 4'b0001; run(1);
        cmp("clear_edit", 32'(pattern_col), 32'h0);
        clear = 1'b0; pad = 4'b0000;

        // Clear mid-PLAY: issuing step still uses old pattern
        sel_step = 3'd0; pad = 4'b1111; run(1);
        sel_step = 3'd1; pad = 4'b1111; run(1);
        pad = 4'b0000; period = 16'd1; mode = 2'd1; run(1);
        cmp("clrplay_entry", 32'(trig), 32'hF);
        run(1);
        clear = 1'b1; run(1);
        cmp("clrplay_cur", 32'(trig), 32'hF);
        cmp("clrplay_cur_step", 32'(step), 32'h1);
        clear = 1'b0; run(2);
        cmp("clrplay_later", 32'(trig), 32'h0);
        cmp("clrplay_later_tick", 32'(step_tick), 32'h1);

        // Lowering period below cnt advances at the next edge
        mode = 2'd0; sel_step = 3'd5; pad = 4'b1001; run(1);
        cmp("edit5", 32'(pattern_col), 32'h9);
        pad = 4'b0000; period = 16'd100; mode = 2'd1; run(1);
        run(50);
        cmp("slow_no_tick", 32'(step_tick), 32'h0);
        period = 16'd10; run(1);
        cmp("drop_period_tick", 32'(step_tick), 32'h1);
        cmp("drop_period_step", 32'(step), 32'h1);

        // Async reset mid-PLAY
        #2 rst_n = 1'b0; #1;
        cmp("arst_trig", 32'(trig), 32'h0);
        cmp("arst_step", 32'(step), 32'h0);
        cmp("arst_tick", 32'(step_tick), 32'h0);
        cmp("arst_col", 32'(pattern_col), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; run(1);
        cmp("post_rst_tick", 32'(step_tick), 32'h1);
        cmp("post_rst_trig", 32'(trig), 32'h0);
        run(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/drum_step_sequencer.md
# drum_step_sequencer

Pattern store and playback engine for the drum machine. It holds a STEPS x TRACKS bit pattern and behaves according to the system mode:
- EDIT: pad strobes toggle pattern bits at a cursor step.
- PLAY: a tempo counter advances a playhead and fires per-track trigger pulses.
- RAW: pad strobes pass straight through to the triggers.

It sits between the mode controller (source of `mode`) and the voice/sample engines (consumers of `trig`).

## Interface
- TRACKS, 4, number of drum tracks (pads/voices)
- STEPS, 8, steps per pattern; power of two, >= 2
- SW, $clog2(STEPS), step index width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mode  in  2  0=EDIT, 1=PLAY, 2=RAW, 3=treated as EDIT
- pad  in  TRACKS  one-cycle press strobes, synchronous and already debounced
- sel_step  in  SW  edit cursor step
- clear  in  1  one-cycle strobe: erase whole pattern
- period  in  16  clocks per step minus 1 (0 = one step per clock)
- trig  out  TRACKS  registered one-cycle trigger pulses, one bit per track
- step  out  SW  registered current playhead
- step_tick  out  1  registered; high for the cycle a step is issued in PLAY
- pattern_col  out  TRACKS  combinational read, pattern[sel_step]

## Operation
- Reset (rst_n low, async): state=S_EDIT, pattern all 0, cnt=0, step=0, trig=0, step_tick=0.
- FSM states: S_EDIT, S_PLAY, S_RAW. Each edge loads state from `mode`, with 3 mapping to S_EDIT.
- S_EDIT / mode EDIT:
  - `pad[t]` high toggles pattern[sel_step][t]; several bits in one cycle each toggle.
  - trig=0, step_tick=0, step=0, cnt=0.
- Entry to PLAY (state!=S_PLAY, mode==PLAY) at the edge:
  - step<=0, cnt<=0, trig<=pattern[0], step_tick<=1.
- In S_PLAY (state==S_PLAY, mode==PLAY):
  - If cnt>=period: cnt<=0, step<=step+1 (wraps STEPS-1 to 0), trig<=pattern[step+1], step_tick<=1.
  - Otherwise: cnt<=cnt+1, trig<=0, step_tick<=0.
  - `pad` is ignored.
- S_RAW / mode RAW:
  - trig<=pad, giving 1-cycle latency.
  - step=0, cnt=0, step_tick=0; pattern unchanged.
- Leaving PLAY: at the first edge with mode!=PLAY, step<=0, cnt<=0, step_tick<=0. trig follows the new mode's rule.
- clear, any mode:
  - Pattern all 0 at the next edge.
  - Beats a pad toggle in the same cycle; the toggle is lost.
- Triggers issued at an edge read the pattern contents before that edge. A same-cycle clear or toggle affects later steps only.
- `cnt` is 16-bit. The `>=` compare means lowering `period` below the current cnt advances at the next edge; no wrap-through of 65536.
- `pattern_col` reflects writes the cycle after the writing edge.

## Timing
- EDIT toggle: visible on pattern_col 1 cycle after the strobe.
- PLAY entry: first trig/step_tick in the cycle after the mode change is seen at an edge.
- Step spacing in steady PLAY: exactly period+1 clocks between step_tick pulses.
- RAW: trig = pad delayed 1 clock.
- Mode switch mid-step: takes effect at the next edge; no partial step completes.
- Reset asserted mid-operation clears everything immediately (async). First activity follows rst_n deassertion on the next edge per the current mode.

## Test plan
- Reset, then EDIT with sel_step=2, pad=4'b0101 for 1 cycle -> pattern_col=0101 next cycle; repeat the strobe -> 0000.
- Pattern step0=0001, step1=0010, rest 0; period=3; mode=PLAY:
  - trig=0001 one cycle after entry, step=0.
  - 4 clocks later trig=0010, step=1.
  - step_tick every 4 clocks; step wraps 7->0 with trig=0001 again.
- period=0, mode=PLAY -> step_tick high every cycle; step increments each clock and wraps at 8.
- RAW: pad=1000 for 1 cycle -> trig=1000 exactly one cycle later; pattern unchanged; step=0.
- Clear in the same cycle as pad strobe in EDIT -> pattern_col=0000. Clear mid-PLAY -> the current step's trig still fires, all later trig=0.
- period=100, cnt at 50, period changed to 10 -> advance at the next edge. Then drop rst_n mid-PLAY -> trig, step, step_tick 0 immediately and pattern zeroed.
